// File: rtl/mac_arbiter_if.sv
// mac_arbiter_if: operand/result bus between N_REQ requesters and the
// shared multiply-add arbiter.
//   req_valid  per-requester request valid
//   req_a/b/c  packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot (or zero) grant back to the requesters
//   res_valid  one-cycle result pulse
//   res_id     requester that owns res_data
//   res_data   A*B + C
// modport master: requester/consumer side; modport slave: arbiter side.
interface mac_arbiter_if #(
    parameter int WIDTH     = 8,
    parameter int N_REQ     = 4,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int OUT_WIDTH = 2 * WIDTH
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*WIDTH-1:0] req_c;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic [ID_W-1:0]        res_id;
    logic [OUT_WIDTH-1:0]   res_data;

    modport master (
        output req_valid, req_a, req_b, req_c,
        input  req_ready, res_valid, res_id, res_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c,
        output req_ready, res_valid, res_id, res_data
    );
endinterface

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin arbiter that shares one two-stage multiply-add
// pipeline (A*B + C) between N_REQ requesters and tags each result with the
// originating requester index.
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   hold         blocks new grants; in-flight entries keep draining
//   bus          mac_arbiter_if.slave (requests in, grants and results out)
//   busy         high while either pipeline stage holds a valid entry
//   issue_count  number of accepted requests, wraps modulo 2^16
module mac_arbiter #(
    parameter int WIDTH     = 8,
    parameter int OUT_WIDTH = 16,
    parameter int N_REQ     = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    mac_arbiter_if.slave         bus,
    output logic                 busy,
    output logic [15:0]          issue_count
);

    logic [WIDTH-1:0]     a_arr [N_REQ];
    logic [WIDTH-1:0]     b_arr [N_REQ];
    logic [WIDTH-1:0]     c_arr [N_REQ];

    logic [ID_W-1:0]      ptr_reg;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      scan_idx;
    logic                 found;
    logic                 grant;

    logic                 s1_v_reg;
    logic [OUT_WIDTH-1:0] s1_prod_reg;
    logic [WIDTH-1:0]     s1_c_reg;
    logic [ID_W-1:0]      s1_id_reg;

    logic                 res_valid_reg;
    logic [ID_W-1:0]      res_id_reg;
    logic [OUT_WIDTH-1:0] res_data_reg;
    logic [15:0]          issue_count_reg;

    // Unpack the flat operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
            assign c_arr[gi] = bus.req_c[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from ptr upward; ID_W-bit addition wraps modulo N_REQ because
    // N_REQ is a power of two.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ptr_reg + ID_W'(k);
            if (!found && bus.req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // A grant is always a transfer: ready is only raised where valid is high.
    assign grant = found && !hold && !reset;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant && (winner == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg         <= '0;
            s1_v_reg        <= 1'b0;
            s1_prod_reg     <= '0;
            s1_c_reg        <= '0;
            s1_id_reg       <= '0;
            res_valid_reg   <= 1'b0;
            res_id_reg      <= '0;
            res_data_reg    <= '0;
            issue_count_reg <= '0;
        end else begin
            s1_v_reg <= grant;
            if (grant) begin
                ptr_reg         <= winner + ID_W'(1);
                // Widen before multiplying so the product is full OUT_WIDTH.
                s1_prod_reg     <= OUT_WIDTH'(a_arr[winner]) * OUT_WIDTH'(b_arr[winner]);
                s1_c_reg        <= c_arr[winner];
                s1_id_reg       <= winner;
                issue_count_reg <= issue_count_reg + 16'd1;
            end

            // C is added one stage after the multiply, alongside its product.
            res_valid_reg <= s1_v_reg;
            if (s1_v_reg) begin
                res_data_reg <= s1_prod_reg + OUT_WIDTH'(s1_c_reg);
                res_id_reg   <= s1_id_reg;
            end
        end
    end

    assign bus.res_valid = res_valid_reg;
    assign bus.res_id    = res_id_reg;
    assign bus.res_data  = res_data_reg;
    assign busy          = s1_v_reg | res_valid_reg;
    assign issue_count   = issue_count_reg;

endmodule

// File: tb/tb_mac_arbiter.sv
module tb_mac_arbiter;

    localparam int WIDTH     = 8;
    localparam int OUT_WIDTH = 16;
    localparam int N_REQ     = 4;
    localparam int ID_W      = 2;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        busy;
    logic [15:0] issue_count;

    int n_vec = 0;
    int n_err = 0;

    // Expected results: {id, data}
    logic [ID_W+OUT_WIDTH-1:0] exp_q[$];

    mac_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .OUT_WIDTH(OUT_WIDTH)) bus ();

    mac_arbiter #(
        .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hold(hold),
        .bus(bus),
        .busy(busy),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.req_a[i*WIDTH +: WIDTH] = a;
        bus.req_b[i*WIDTH +: WIDTH] = b;
        bus.req_c[i*WIDTH +: WIDTH] = c;
    endtask

    // One cycle of stimulus: apply inputs, check the combinational grant and
    // queue the hand-computed result when a transfer is expected.
    task automatic drive(input logic [3:0] v, input logic h, input logic [3:0] exp_rdy,
                         input logic [1:0] exp_id, input logic [15:0] exp_data, input logic push);
        @(negedge clk);
        bus.req_valid = v;
        hold = h;
        #1;
        check($sformatf("ready v=%b h=%b", v, h), 32'(bus.req_ready), 32'(exp_rdy));
        if (push && exp_rdy != 4'b0000) exp_q.push_back({exp_id, exp_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'b0000, 1'b0, 4'b0000, 2'd0, 16'd0, 1'b0);
    endtask

    // Monitor: every res_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.res_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL result: unexpected id=%0d data=%0d, expected none", bus.res_id, bus.res_data);
            end else begin
                logic [ID_W+OUT_WIDTH-1:0] e;
                e = exp_q.pop_front();
                if ({bus.res_id, bus.res_data} !== e) begin
                    n_err++;
                    $display("FAIL result: got id=%0d data=%0d, expected id=%0d data=%0d",
                             bus.res_id, bus.res_data, e[ID_W+OUT_WIDTH-1 -: ID_W], e[OUT_WIDTH-1:0]);
                end else begin
                    $display("ok   result: id=%0d data=%0d", bus.res_id, bus.res_data);
                end
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, " res_id"}, 32'(bus.res_id), 32'd0);
        check({tag, " res_data"}, 32'(bus.res_data), 32'd0);
        check({tag, " issue_count"}, 32'(issue_count), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        hold = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;

        // Reset: ready gated off even with all requesters valid.
        repeat (2) @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        check("ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        reset = 1'b0;
        #1;
        check_cleared("reset_state");

        // Single request from requester 1: 3*4+5 = 17. ptr -> 2.
        set_ops(1, 8'd3, 8'd4, 8'd5);
        drive(4'b0010, 1'b0, 4'b0010, 2'd1, 16'd17, 1'b1);
        idle(3);
        check("issue_count_1", 32'(issue_count), 32'd1);

        // Max operands on requester 3: 255*255+255 = 65280. ptr -> 0.
        set_ops(3, 8'd255, 8'd255, 8'd255);
        drive(4'b1000, 1'b0, 4'b1000, 2'd3, 16'd65280, 1'b1);
        idle(1);

        // Round robin, all valid for 8 cycles. Lane i: a=i+1, b=2, c=i -> 3i+2.
        set_ops(0, 8'd1, 8'd2, 8'd0);
        set_ops(1, 8'd2, 8'd2, 8'd1);
        set_ops(2, 8'd3, 8'd2, 8'd2);
        set_ops(3, 8'd4, 8'd2, 8'd3);
        for (int r = 0; r < 2; r++) begin
            drive(4'b1111, 1'b0, 4'b0001, 2'd0, 16'd2, 1'b1);
            drive(4'b1111, 1'b0, 4'b0010, 2'd1, 16'd5, 1'b1);
            drive(4'b1111, 1'b0, 4'b0100, 2'd2, 16'd8, 1'b1);
            drive(4'b1111, 1'b0, 4'b1000, 2'd3, 16'd11, 1'b1);
        end
        idle(3);
        check("issue_count_rr", 32'(issue_count), 32'd10);

        // Hold with requester 2 valid: no grants; then granted first cycle.
        set_ops(2, 8'd10, 8'd10, 8'd7);
        for (int i = 0; i < 5; i++) drive(4'b0100, 1'b1, 4'b0000, 2'd0, 16'd0, 1'b0);
        check("busy_after_hold", 32'(busy), 32'd0);
        drive(4'b0100, 1'b0, 4'b0100, 2'd2, 16'd107, 1'b1);   // ptr -> 3
        idle(1);

        // Steer ptr to 1, then requesters 0 and 3: 3 first, then 0, then ptr=1.
        drive(4'b0001, 1'b0, 4'b0001, 2'd0, 16'd2, 1'b1);
        drive(4'b1001, 1'b0, 4'b1000, 2'd3, 16'd11, 1'b1);
        drive(4'b1001, 1'b0, 4'b0001, 2'd0, 16'd2, 1'b1);
        drive(4'b0011, 1'b0, 4'b0010, 2'd1, 16'd5, 1'b1);
        idle(3);
        check("issue_count_ptr", 32'(issue_count), 32'd15);

        // Reset mid-flight: first result already left stage 2 when reset is
        // sampled, the second is discarded.
        drive(4'b0001, 1'b0, 4'b0001, 2'd0, 16'd2, 1'b1);
        drive(4'b0010, 1'b0, 4'b0010, 2'd1, 16'd5, 1'b0);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_cleared("after_reset");

        // ptr restarted at 0.
        drive(4'b1111, 1'b0, 4'b0001, 2'd0, 16'd2, 1'b1);
        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
